// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-FSM state encodings and the
// datapath select encodings used by control_unit, datapath and ALU.
package cpu_pkg;

  localparam int OPCODE_W = 5;
  localparam int STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 5'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 5'h01;
  localparam logic [OPCODE_W-1:0] OP_SW    = 5'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 5'h03;
  localparam logic [OPCODE_W-1:0] OP_J     = 5'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'h05;

  typedef enum logic [STATE_W-1:0] {
    FETCH0  = 4'd0,
    FETCH1  = 4'd1,
    FETCH2  = 4'd2,
    DECODE  = 4'd3,
    MEMADR  = 4'd4,
    LW_RD   = 4'd5,
    LW_WB   = 4'd6,
    SW_WR   = 4'd7,
    RT_EX   = 4'd8,
    RT_WB   = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11,
    BRANCH  = 4'd12,
    JUMP    = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B        = 2'b00,
    SRCB_CONST4   = 2'b01,
    SRCB_IMM      = 2'b10,
    SRCB_IMM_SHL2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_e;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle control FSM for the 24-bit datapath: fetches a 3-byte
// instruction, decodes it and sequences execute/memory/write-back steps.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                aluSrcA,
  output logic                mem_to_reg,
  output logic                data_not_instr,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                reg_write,
  output logic                reg_dst,
  output logic [1:0]          pc_source,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic [2:0]          ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state
);

  state_e state_q, state_d;
  logic   illegal_q;
  logic   zero_unused;

  // zero is consumed by the datapath PC-write gating, not by this FSM
  assign zero_unused = zero;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH0;
    else       state_q <= state_d;
  end

  // Illegal-opcode flag: pulses in the cycle after DECODE saw a bad opcode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (state_q == DECODE) && !is_legal_op(opcode);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH0:  if (mem_ready) state_d = FETCH1;
      FETCH1:  if (mem_ready) state_d = FETCH2;
      FETCH2:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = RT_EX;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default:      state_d = FETCH0;
        endcase
      end
      MEMADR:  state_d = (opcode == OP_LW) ? LW_RD : SW_WR;
      LW_RD:   if (mem_ready) state_d = LW_WB;
      LW_WB:   state_d = FETCH0;
      SW_WR:   if (mem_ready) state_d = FETCH0;
      RT_EX:   state_d = RT_WB;
      RT_WB:   state_d = FETCH0;
      ADDI_EX: state_d = ADDI_WB;
      ADDI_WB: state_d = FETCH0;
      BRANCH:  state_d = FETCH0;
      JUMP:    state_d = FETCH0;
      default: state_d = FETCH0;
    endcase
  end

  // Output decode; fetch strobes are qualified by mem_ready so each IR byte
  // loads exactly once, and everything is forced low while reset is held
  always_comb begin
    aluSrcA        = 1'b0;
    mem_to_reg     = 1'b0;
    data_not_instr = 1'b0;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    pc_source      = PC_SRC_ALU;
    aluSrcB        = SRCB_B;
    aluOp          = ALU_ADD;
    ir_write       = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH0: begin
          mem_read = 1'b1;
          if (mem_ready) ir_write = 3'b001;
        end
        FETCH1: begin
          mem_read = 1'b1;
          if (mem_ready) ir_write = 3'b010;
        end
        FETCH2: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 3'b100;
            pc_write = 1'b1;
            aluSrcB  = SRCB_CONST4;
          end
        end
        DECODE: aluSrcB = SRCB_IMM_SHL2;
        MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
        end
        LW_RD: begin
          mem_read       = 1'b1;
          data_not_instr = 1'b1;
        end
        LW_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        SW_WR: begin
          mem_write      = 1'b1;
          data_not_instr = 1'b1;
        end
        RT_EX: begin
          aluSrcA = 1'b1;
          aluOp   = ALU_FUNCT;
        end
        RT_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ADDI_EX: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
        end
        ADDI_WB: reg_write = 1'b1;
        BRANCH: begin
          aluSrcA       = 1'b1;
          aluOp         = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_SRC_ALUOUT;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign illegal_op = illegal_q;
  assign state      = STATE_W'(state_q);

endmodule
